store_write_buffer: RTL and testbench

- FIFO store buffer between the data cache stage and data RAM.
- The cache stage updates its own line on a store and pushes the store here. This block drains stores to RAM one at a time over a req/ack handshake, so the pipeline does not wait on RAM write latency.
- It also flags loads that alias a pending store, so the pipeline stalls until that store has reached RAM.

---
 rtl/store_write_buffer.sv | 166 ++++++++++++++++
 tb/tb_store_write_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
// store_write_buffer
//   FIFO of pending stores between the data cache stage and data RAM. Stores
//   are accepted from the cache stage and drained to RAM one at a time over a
//   req/ack handshake. Loads that hit a pending store's word are flagged so
//   the pipeline can stall until that store has reached RAM.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   push_en/addr/data/width   store in (width: 000 SW, 001 SH, 010 SB)
//   full, empty, count  occupancy
//   ld_en, ld_addr      load probe; ld_conflict is the combinational result
//   mem_req/addr/wdata/width  head-of-queue write request to RAM
//   mem_ack             RAM accepted the current request

// One buffered store plus its word-address compare against the load probe.
module swb_entry (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr,
  input  logic        clr,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [2:0]  wr_width,
  input  logic [29:0] ld_word,
  output logic        vld,
  output logic [31:0] addr,
  output logic [31:0] data,
  output logic [2:0]  width,
  output logic        hit
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld <= 1'b0;
    else if (wr)  vld <= 1'b1;
    else if (clr) vld <= 1'b0;
  end

  // Payload needs no reset: it is only observed while vld is set.
  always_ff @(posedge clk) begin
    if (wr) begin
      addr  <= wr_addr;
      data  <= wr_data;
      width <= wr_width;
    end
  end

  // Word granularity only; byte lanes are ignored so the check is conservative.
  assign hit = vld && (addr[31:2] == ld_word);

endmodule

module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_en,
  input  logic [31:0]      push_addr,
  input  logic [31:0]      push_data,
  input  logic [2:0]       push_width,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  input  logic             ld_en,
  input  logic [31:0]      ld_addr,
  output logic             ld_conflict,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [2:0]       mem_width,
  input  logic             mem_ack
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t             state;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               push_ok, pop;
  logic [PTR_W:0]     count_nxt;
  logic [2:0]         width_n;

  logic [DEPTH-1:0]         e_vld, e_hit;
  logic [DEPTH-1:0][31:0]   e_addr, e_data;
  logic [DEPTH-1:0][2:0]    e_width;

  // Low address bits play no part in the word-granular alias check.
  logic unused_ld_lsb;
  assign unused_ld_lsb = ^ld_addr[1:0];

  // Push is judged on the pre-pop count, so a push at full is rejected even
  // when the same edge pops.
  assign push_ok = push_en && (count != DEPTH_C);
  assign pop     = (state == REQ) && mem_ack;

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  assign width_n = (push_width == 3'b001 || push_width == 3'b010) ? push_width : 3'b000;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    swb_entry u_ent (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr       (push_ok && (wr_ptr == PTR_W'(i))),
      .clr      (pop && (rd_ptr == PTR_W'(i))),
      .wr_addr  (push_addr),
      .wr_data  (push_data),
      .wr_width (width_n),
      .ld_word  (ld_addr[31:2]),
      .vld      (e_vld[i]),
      .addr     (e_addr[i]),
      .data     (e_data[i]),
      .width    (e_width[i]),
      .hit      (e_hit[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      state   <= IDLE;
      mem_req <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      case (state)
        IDLE: if (count_nxt != '0) begin
          state   <= REQ;
          mem_req <= 1'b1;
        end
        REQ: if (pop && count_nxt == '0) begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // Head entry is not overwritten while pending, so these hold until ack.
  assign mem_addr  = e_addr[rd_ptr];
  assign mem_wdata = e_data[rd_ptr];
  assign mem_width = e_width[rd_ptr];

  // A store pushed this cycle is not yet valid, so it never counts here.
  assign ld_conflict = ld_en && (|e_hit);

endmodule

// File: tb/tb_store_write_buffer.sv
module tb_store_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        push_en;
  logic [31:0] push_addr, push_data;
  logic [2:0]  push_width;
  logic        full, empty;
  logic [2:0]  count;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic        mem_req;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_width;
  logic        mem_ack;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  width;
  } st_t;

  st_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;

  always #10 clk = ~clk;

  store_write_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_en(push_en), .push_addr(push_addr), .push_data(push_data), .push_width(push_width),
    .full(full), .empty(empty), .count(count),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_width(mem_width),
    .mem_ack(mem_ack)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a store for the next edge; queue its expected drain if it should be accepted.
  task automatic drive_push(input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] w, input logic [2:0] w_exp, input bit accept);
    st_t e;
    push_en = 1'b1; push_addr = a; push_data = d; push_width = w;
    if (accept) begin
      e.addr = a; e.data = d; e.width = w_exp;
      sb.push_back(e);
    end
  endtask

  // Monitor: each accepted RAM write must match the next expected store.
  always @(negedge clk) begin
    if (rst_n && mem_req && mem_ack) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_store: got addr %h expected none", mem_addr);
      end else begin
        st_t e;
        e = sb.pop_front();
        chk("drain_addr",  mem_addr,  e.addr);
        chk("drain_data",  mem_wdata, e.data);
        chk("drain_width", {29'd0, mem_width}, {29'd0, e.width});
      end
    end
  end

  initial begin
    rst_n = 1'b0; push_en = 1'b0; push_addr = '0; push_data = '0; push_width = '0;
    ld_en = 1'b0; ld_addr = '0; mem_ack = 1'b0;
    #5;
    chk("rst_req",   {31'd0, mem_req}, 32'd0);
    chk("rst_count", {29'd0, count},   32'd0);
    chk("rst_full",  {31'd0, full},    32'd0);
    chk("rst_empty", {31'd0, empty},   32'd1);
    step();
    rst_n = 1'b1;
    step();

    // Single store with ack held high: one-cycle request.
    mem_ack = 1'b1;
    drive_push(32'h100, 32'hDEADBEEF, 3'b000, 3'b000, 1'b1);
    step();
    push_en = 1'b0;
    chk("single_req_on", {31'd0, mem_req}, 32'd1);
    step();
    chk("single_req_off", {31'd0, mem_req}, 32'd0);
    chk("single_empty",   {31'd0, empty},   32'd1);

    // Fill with ack low; 5th push dropped.
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_push(32'(4*i), 32'h1000 + 32'(i), 3'b000, 3'b000, i < 4);
      step();
    end
    push_en = 1'b0;
    chk("fill_full",  {31'd0, full},  32'd1);
    chk("fill_count", {29'd0, count}, 32'd4);
    mem_ack = 1'b1;
    repeat (4) step();
    chk("fill_drained", {31'd0, empty},   32'd1);
    chk("fill_req_off", {31'd0, mem_req}, 32'd0);
    mem_ack = 1'b0;

    // Handshake hold: head stays stable while new stores arrive.
    drive_push(32'h300, 32'h11, 3'b001, 3'b001, 1'b1);
    step();
    for (int i = 0; i < 7; i++) begin
      if (i < 3) drive_push(32'h304 + 32'(4*i), 32'(i), 3'b010, 3'b010, 1'b1);
      else       drive_push(32'h3F0, 32'hBAD, 3'b010, 3'b010, 1'b0);
      step();
      chk("hold_addr",  mem_addr,  32'h300);
      chk("hold_data",  mem_wdata, 32'h11);
      chk("hold_width", {29'd0, mem_width}, 32'd1);
      chk("hold_req",   {31'd0, mem_req},   32'd1);
    end
    chk("hold_full", {31'd0, full}, 32'd1);

    // Push and pop on the same edge at full: push rejected.
    mem_ack = 1'b1;
    drive_push(32'h400, 32'hBAD, 3'b000, 3'b000, 1'b0);
    step();
    push_en = 1'b0;
    chk("pp_count", {29'd0, count}, 32'd3);
    chk("pp_full",  {31'd0, full},  32'd0);
    repeat (3) step();
    chk("pp_empty", {31'd0, empty}, 32'd1);

    // Steady-state wrap-around; illegal width codes become SW.
    for (int i = 0; i < 10; i++) begin
      logic [2:0] w, we;
      w  = (i % 4 == 3) ? 3'b101 : 3'(i % 4);
      we = (i % 4 == 3) ? 3'b000 : w;
      drive_push(32'h500 + 32'(4*i), 32'hA0 + 32'(i), w, we, 1'b1);
      step();
      chk("wrap_count", {29'd0, count}, 32'd1);
    end
    push_en = 1'b0;
    step();
    chk("wrap_empty", {31'd0, empty}, 32'd1);
    mem_ack = 1'b0;

    // Load conflict.
    drive_push(32'h203, 32'hAB, 3'b010, 3'b010, 1'b1);
    step();
    push_en = 1'b0;
    ld_en = 1'b1; ld_addr = 32'h200; #1;
    chk("ld_same_word", {31'd0, ld_conflict}, 32'd1);
    ld_addr = 32'h204; #1;
    chk("ld_next_word", {31'd0, ld_conflict}, 32'd0);
    drive_push(32'h208, 32'hCD, 3'b000, 3'b000, 1'b1);
    ld_addr = 32'h208; #1;
    chk("ld_same_cycle_push", {31'd0, ld_conflict}, 32'd0);
    step();
    push_en = 1'b0; #1;
    chk("ld_after_push", {31'd0, ld_conflict}, 32'd1);
    ld_en = 1'b0; #1;
    chk("ld_disabled", {31'd0, ld_conflict}, 32'd0);
    ld_en = 1'b1; ld_addr = 32'h200; mem_ack = 1'b1; #1;
    chk("ld_popping", {31'd0, ld_conflict}, 32'd1);
    step();
    chk("ld_after_pop", {31'd0, ld_conflict}, 32'd0);
    step();
    mem_ack = 1'b0; ld_en = 1'b0;
    chk("ld_empty", {31'd0, empty}, 32'd1);

    // Asynchronous reset with stores pending.
    for (int i = 0; i < 3; i++) begin
      drive_push(32'h600 + 32'(4*i), 32'(i), 3'b000, 3'b000, 1'b1);
      step();
    end
    push_en = 1'b0;
    chk("ar_count_pre", {29'd0, count},   32'd3);
    chk("ar_req_pre",   {31'd0, mem_req}, 32'd1);
    #11;
    rst_n = 1'b0;
    #1;
    chk("ar_req",   {31'd0, mem_req}, 32'd0);
    chk("ar_count", {29'd0, count},   32'd0);
    chk("ar_full",  {31'd0, full},    32'd0);
    chk("ar_empty", {31'd0, empty},   32'd1);
    sb.delete();
    step();
    rst_n = 1'b1;
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ar_no_stale", {31'd0, mem_req}, 32'd0);
    end
    mem_ack = 1'b0;

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
